// File: rtl/i2s_tx.sv
// I2S transmitter: mono sample sent in both slots of a standard I2S frame.
// A one-entry holding register decouples the sample source from the frame timing.
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] K_LAST   = BIT_W'(2 * DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] K_HALF   = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(2 * DATA_WIDTH - 2);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] frame_word;

  logic                  div_wrap;
  logic                  fall_edge;
  logic                  load_edge;
  logic                  accept;
  logic [BIT_W-1:0]      next_k;
  logic [BIT_W-1:0]      slot_idx;
  logic [DATA_WIDTH-1:0] frame_next;
  logic [DATA_WIDTH-1:0] frame_shifted;
  logic                  next_sdata;
  logic                  next_lrclk;

  // Handshake: a sample transfers on any cycle with in_valid && in_ready;
  // in_ready depends only on hold_full, never on in_valid.
  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;

  always_comb begin
    div_wrap      = (div_cnt == DIV_LAST);
    fall_edge     = div_wrap && bclk;
    next_k        = (bit_cnt == K_LAST) ? '0 : bit_cnt + BIT_W'(1);
    load_edge     = fall_edge && (next_k == '0);
    frame_next    = frame_word;
    if (load_edge) begin
      frame_next = hold_full ? hold : '0;
    end
    // Both slots carry the same word, so only the position within the slot matters.
    slot_idx      = (next_k < K_HALF) ? next_k : next_k - K_HALF;
    frame_shifted = frame_next << slot_idx;
    next_sdata    = frame_shifted[DATA_WIDTH-1];
    next_lrclk    = (next_k >= LR_LO) && (next_k <= LR_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= K_LAST;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      hold       <= '0;
      hold_full  <= 1'b0;
      frame_word <= '0;
    end else begin
      underrun <= 1'b0;
      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_edge) begin
        bit_cnt    <= next_k;
        lrclk      <= next_lrclk;
        sdata      <= next_sdata;
        frame_word <= frame_next;
        if (load_edge) begin
          underrun  <= !hold_full;
          hold_full <= 1'b0;
        end
      end
      // A sample arriving on an empty-hold load edge waits for the next frame.
      if (accept) begin
        hold      <= audio_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at DATA_WIDTH=16, BCLK_DIV=4: startup vector table
// followed by frame-level sequences for load-edge, underrun and reset cases.
module tb_i2s_tx;

  logic        clk;
  logic        reset;
  logic [15:0] audio_in;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int ur_seen = 0;

  i2s_tx #(.DATA_WIDTH(16), .BCLK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .audio_in (audio_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (underrun === 1'b1) ur_seen++;
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] din;
    logic        e_bclk;
    logic        e_lrclk;
    logic        e_sdata;
    logic        e_underrun;
    logic        e_in_ready;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Entered one clk before a falling edge whose new bit index is start_k;
  // leaves one clk before the next frame's load edge.
  task automatic check_frame(input logic [15:0] word, input logic exp_ur, input int start_k);
    logic [15:0] w;
    w = word;
    for (int k = start_k; k < 32; k++) begin
      tick();
      chk("fall_bclk", {31'b0, bclk}, 32'd0);
      chk($sformatf("sdata_k%0d", k), {31'b0, sdata}, {31'b0, w[15 - (k % 16)]});
      chk($sformatf("lrclk_k%0d", k), {31'b0, lrclk}, {31'b0, (k >= 15 && k <= 30)});
      if (k == 0) chk("load_underrun", {31'b0, underrun}, {31'b0, exp_ur});
      repeat (7) tick();
    end
  endtask

  initial begin
    int ur_base;
    reset    = 1'b1;
    in_valid = 1'b0;
    audio_in = 16'h0000;
    repeat (3) tick();

    // Startup: reset ignores in_valid, bclk rises at 4, first fall at 8 is an underrun load.
    vecs[0]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      reset    = vecs[i].rst;
      in_valid = vecs[i].vld;
      audio_in = vecs[i].din;
      tick();
      chk($sformatf("v%0d_bclk", i),     {31'b0, bclk},     {31'b0, vecs[i].e_bclk});
      chk($sformatf("v%0d_lrclk", i),    {31'b0, lrclk},    {31'b0, vecs[i].e_lrclk});
      chk($sformatf("v%0d_sdata", i),    {31'b0, sdata},    {31'b0, vecs[i].e_sdata});
      chk($sformatf("v%0d_underrun", i), {31'b0, underrun}, {31'b0, vecs[i].e_underrun});
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_in_ready});
    end
    in_valid = 1'b0;

    // 0xA5C3 accepted before the first load edge goes out in both slots.
    do_reset();
    in_valid = 1'b1;
    audio_in = 16'hA5C3;
    tick();
    chk("a5c3_accepted", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (6) tick();
    check_frame(16'hA5C3, 1'b0, 0);
    chk("a5c3_hold_empty", {31'b0, in_ready}, 32'd1);

    // Three idle frames: exactly three underrun pulses, data all zero.
    do_reset();
    repeat (7) tick();
    ur_base = ur_seen;
    for (int f = 0; f < 3; f++) check_frame(16'h0000, 1'b1, 0);
    chk("idle_underrun_count", ur_seen - ur_base, 32'd3);

    // in_valid held high: 0x1234 now, 0x5678 the cycle after the load edge.
    do_reset();
    in_valid = 1'b1;
    audio_in = 16'h1234;
    tick();
    chk("b2b_first_accept", {31'b0, in_ready}, 32'd0);
    audio_in = 16'h5678;
    repeat (6) tick();
    chk("b2b_stalled", {31'b0, in_ready}, 32'd0);
    tick();
    chk("b2b_load_ready", {31'b0, in_ready}, 32'd1);
    chk("b2b_load_underrun", {31'b0, underrun}, 32'd0);
    chk("b2b_load_msb", {31'b0, sdata}, 32'd0);
    tick();
    chk("b2b_second_accept", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (6) tick();
    check_frame(16'h1234, 1'b0, 1);
    check_frame(16'h5678, 1'b0, 0);

    // Reset in the right slot with hold full discards everything.
    do_reset();
    in_valid = 1'b1;
    audio_in = 16'h1111;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    in_valid = 1'b1;
    audio_in = 16'h2222;
    tick();
    chk("mid_hold_full", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (161) tick();
    chk("mid_right_slot", {31'b0, lrclk}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_bclk", {31'b0, bclk}, 32'd0);
    chk("mid_rst_lrclk", {31'b0, lrclk}, 32'd0);
    chk("mid_rst_sdata", {31'b0, sdata}, 32'd0);
    chk("mid_rst_underrun", {31'b0, underrun}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (7) tick();
    check_frame(16'h0000, 1'b1, 0);

    // Sample offered exactly on an empty-hold load edge: no bypass.
    do_reset();
    repeat (7) tick();
    in_valid = 1'b1;
    audio_in = 16'h7FFF;
    tick();
    chk("edge_underrun", {31'b0, underrun}, 32'd1);
    chk("edge_accepted", {31'b0, in_ready}, 32'd0);
    chk("edge_msb_zero", {31'b0, sdata}, 32'd0);
    in_valid = 1'b0;
    repeat (7) tick();
    check_frame(16'h0000, 1'b0, 1);
    check_frame(16'h7FFF, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
